// File: rtl/nlfsr_pkg.sv
// Shared definitions for the NLFSR tap loader and the downstream tap-evaluation block.
package nlfsr_pkg;

    localparam int unsigned TAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_ERROR = 2'd3
    } tl_state_e;

    // A tap index is legal when it addresses a real register stage (1..size-1).
    function automatic logic tap_in_range(input logic [TAP_W-1:0] tap, input int unsigned size);
        return (tap != '0) && (32'(tap) < size);
    endfunction

endpackage

// File: rtl/tap_range_check.sv
// Combinational legality check of one tap index byte against the NLFSR length.
module tap_range_check
    import nlfsr_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic [TAP_W-1:0] din,
    output logic             ok
);

    assign ok = tap_in_range(din, SIZE);

endmodule

// File: rtl/tap_loader.sv
// Collects NUM_OF_TAPS tap index bytes into a staging buffer and commits them
// atomically to co_buf, raising start while the committed set is armed.
module tap_loader
    import nlfsr_pkg::*;
#(
    parameter int unsigned NUM_OF_TAPS = 16,
    parameter int unsigned SIZE        = 32
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         load,
    input  logic                         stop,
    input  logic                         din_valid,
    input  logic [7:0]                   din,
    output logic                         din_ready,
    output logic [NUM_OF_TAPS*TAP_W-1:0] co_buf,
    output logic                         start,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned BUF_W = NUM_OF_TAPS * TAP_W;
    localparam int unsigned CNT_W = $clog2(NUM_OF_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OF_TAPS - 1);

    tl_state_e        state;
    logic [BUF_W-1:0] staging;
    logic [BUF_W-1:0] staging_upd;
    logic [CNT_W-1:0] cnt;
    logic             tap_ok;
    logic             accept;

    tap_range_check #(
        .SIZE(SIZE)
    ) u_range (
        .din(din),
        .ok (tap_ok)
    );

    // load has priority over an incoming byte in the same cycle
    assign accept = din_valid && din_ready && !load;

    // Staging with the current byte merged in, so the last byte commits in the same edge
    always_comb begin
        staging_upd                       = staging;
        staging_upd[cnt*TAP_W +: TAP_W]   = din;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= ST_IDLE;
            staging   <= '0;
            co_buf    <= '0;
            cnt       <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            din_ready <= 1'b0;
        end else if (load) begin
            state     <= ST_LOAD;
            staging   <= '0;
            cnt       <= '0;
            start     <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (!tap_ok) begin
                            state     <= ST_ERROR;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            din_ready <= 1'b0;
                        end else if (cnt == LAST_IDX) begin
                            state     <= ST_ARMED;
                            staging   <= staging_upd;
                            co_buf    <= staging_upd;
                            cnt       <= cnt + CNT_W'(1);
                            start     <= 1'b1;
                            busy      <= 1'b0;
                            din_ready <= 1'b0;
                        end else begin
                            staging   <= staging_upd;
                            cnt       <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        start <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_loader.sv
// Self-checking bench for tap_loader: table-driven vectors plus hand-written
// multi-cycle sequences, with expectations queued at drive time and popped after the edge.
module tb_tap_loader;

    localparam int unsigned NT = 16;
    localparam int unsigned BW = NT * 8;

    typedef struct packed {
        logic          ready;
        logic          start;
        logic          busy;
        logic          err;
        logic [BW-1:0] co;
    } exp_t;

    typedef struct packed {
        logic       res;
        logic       load;
        logic       stop;
        logic       valid;
        logic [7:0] din;
        exp_t       e;
    } vec_t;

    logic          clk;
    logic          res;
    logic          load;
    logic          stop;
    logic          din_valid;
    logic [7:0]    din;
    logic          din_ready;
    logic [BW-1:0] co_buf;
    logic          start;
    logic          busy;
    logic          err;

    exp_t q[$];
    int   n_tests;
    int   n_fail;

    tap_loader #(
        .NUM_OF_TAPS(16),
        .SIZE       (32)
    ) dut (
        .clk      (clk),
        .res      (res),
        .load     (load),
        .stop     (stop),
        .din_valid(din_valid),
        .din      (din),
        .din_ready(din_ready),
        .co_buf   (co_buf),
        .start    (start),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic r, input logic s, input logic b, input logic e,
                                input logic [BW-1:0] co);
        exp_t x;
        x.ready = r;
        x.start = s;
        x.busy  = b;
        x.err   = e;
        x.co    = co;
        return x;
    endfunction

    function automatic vec_t mkv(input logic r, input logic l, input logic s, input logic v,
                                 input logic [7:0] d, input exp_t e);
        vec_t x;
        x.res   = r;
        x.load  = l;
        x.stop  = s;
        x.valid = v;
        x.din   = d;
        x.e     = e;
        return x;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic cyc(input logic r, input logic l, input logic s, input logic v,
                       input logic [7:0] d, input exp_t e, input string tag);
        exp_t want;
        res       = r;
        load      = l;
        stop      = s;
        din_valid = v;
        din       = d;
        q.push_back(e);
        @(posedge clk);
        #1;
        want = q.pop_front();
        n_tests++;
        if ({din_ready, start, busy, err, co_buf} !== want) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b start=%b busy=%b err=%b co=%h, want rdy=%b start=%b busy=%b err=%b co=%h",
                     tag, din_ready, start, busy, err, co_buf,
                     want.ready, want.start, want.busy, want.err, want.co);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] act, input logic [7:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tbl[10];
        logic [BW-1:0] set_a;
        logic [BW-1:0] set_b;
        logic [BW-1:0] set_c;
        logic [BW-1:0] set_d;
        logic [BW-1:0] z;

        n_tests   = 0;
        n_fail    = 0;
        res       = 1'b1;
        load      = 1'b0;
        stop      = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        z         = '0;
        for (int i = 0; i < NT; i++) begin
            set_a[i*8 +: 8] = 8'(i + 1);
            set_b[i*8 +: 8] = 8'(31 - i);
            set_c[i*8 +: 8] = 8'(i + 11);
            set_d[i*8 +: 8] = 8'h1f;
        end

        tbl[0] = mkv(1, 0, 0, 0, 8'h00, mk(0, 0, 0, 0, z));  // reset
        tbl[1] = mkv(0, 0, 1, 0, 8'h00, mk(0, 0, 0, 0, z));  // stop in IDLE ignored
        tbl[2] = mkv(0, 0, 0, 1, 8'h05, mk(0, 0, 0, 0, z));  // byte in IDLE refused
        tbl[3] = mkv(0, 1, 0, 0, 8'h00, mk(1, 0, 1, 0, z));  // load
        tbl[4] = mkv(0, 1, 1, 0, 8'h00, mk(1, 0, 1, 0, z));  // load beats stop
        tbl[5] = mkv(0, 0, 0, 1, 8'h00, mk(0, 0, 0, 1, z));  // zero tap rejected
        tbl[6] = mkv(0, 0, 0, 1, 8'h07, mk(0, 0, 0, 1, z));  // ERROR holds
        tbl[7] = mkv(0, 0, 1, 0, 8'h00, mk(0, 0, 0, 1, z));  // stop in ERROR ignored
        tbl[8] = mkv(0, 1, 0, 1, 8'h03, mk(1, 0, 1, 0, z));  // load clears err
        tbl[9] = mkv(1, 1, 0, 1, 8'h04, mk(0, 0, 0, 0, z));  // reset overrides load

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++)
            cyc(tbl[i].res, tbl[i].load, tbl[i].stop, tbl[i].valid, tbl[i].din, tbl[i].e,
                $sformatf("vec%0d", i));

        // Full set 1..16 with valid held high
        cyc(0, 1, 0, 0, 8'h00, mk(1, 0, 1, 0, z), "load_a");
        for (int k = 1; k <= 16; k++)
            cyc(0, 0, 0, 1, 8'(k), (k < 16) ? mk(1, 0, 1, 0, z) : mk(0, 1, 0, 0, set_a),
                $sformatf("byte_a%0d", k));
        chk8("co_lo_a", co_buf[7:0], 8'h01);
        chk8("co_hi_a", co_buf[127:120], 8'h10);
        cyc(0, 0, 0, 1, 8'h09, mk(0, 1, 0, 0, set_a), "extra_refused");
        cyc(0, 0, 1, 0, 8'h00, mk(0, 0, 0, 0, set_a), "stop_armed");
        cyc(0, 0, 1, 0, 8'h00, mk(0, 0, 0, 0, set_a), "stop_idle");

        // Arm set B, then a partial reload keeps B visible, then reset drops everything
        cyc(0, 1, 0, 0, 8'h00, mk(1, 0, 1, 0, set_a), "load_b");
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 0, 1, 8'(31 - k), (k < 15) ? mk(1, 0, 1, 0, set_a) : mk(0, 1, 0, 0, set_b),
                $sformatf("byte_b%0d", k));
        cyc(0, 1, 0, 0, 8'h00, mk(1, 0, 1, 0, set_b), "reload");
        for (int k = 1; k <= 7; k++)
            cyc(0, 0, 0, 1, 8'(k), mk(1, 0, 1, 0, set_b), $sformatf("partial%0d", k));
        cyc(1, 0, 0, 1, 8'h05, mk(0, 0, 0, 0, z), "res_mid_load");

        // load coincident with a byte: that byte is dropped
        cyc(0, 1, 0, 1, 8'h03, mk(1, 0, 1, 0, z), "load_wins");
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 0, 1, 8'(k + 11), (k < 15) ? mk(1, 0, 1, 0, z) : mk(0, 1, 0, 0, set_c),
                $sformatf("byte_c%0d", k));
        chk8("first_byte_c", co_buf[7:0], 8'h0b);

        // Out-of-range third byte
        cyc(0, 1, 0, 0, 8'h00, mk(1, 0, 1, 0, set_c), "load_e");
        cyc(0, 0, 0, 1, 8'h05, mk(1, 0, 1, 0, set_c), "err_b1");
        cyc(0, 0, 0, 1, 8'h06, mk(1, 0, 1, 0, set_c), "err_b2");
        cyc(0, 0, 0, 1, 8'h20, mk(0, 0, 0, 1, set_c), "err_b3");
        cyc(0, 0, 0, 1, 8'h04, mk(0, 0, 0, 1, set_c), "err_hold");

        // Boundary tap SIZE-1 with idle gaps between bytes and a stray stop
        cyc(0, 1, 0, 0, 8'h00, mk(1, 0, 1, 0, set_c), "load_d");
        for (int k = 0; k < 16; k++) begin
            cyc(0, 0, (k == 4), 0, 8'h1f, mk(1, 0, 1, 0, set_c), $sformatf("gap_d%0d", k));
            cyc(0, 0, 0, 1, 8'h1f, (k < 15) ? mk(1, 0, 1, 0, set_c) : mk(0, 1, 0, 0, set_d),
                $sformatf("byte_d%0d", k));
        end
        cyc(0, 0, 0, 0, 8'h00, mk(0, 1, 0, 0, set_d), "armed_hold");
        cyc(0, 1, 1, 0, 8'h00, mk(1, 0, 1, 0, set_d), "load_over_stop");
        cyc(1, 0, 0, 0, 8'h00, mk(0, 0, 0, 0, z), "final_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
